// File: rtl/anb_rd_mem_resp.sv
// ANB read responder: accepts one burst request on the address channel, streams
// consecutive words out of a 1-cycle-latency synchronous RAM, and returns them
// on the data channel through a 3-entry output FIFO with 'last' on the final beat.
module anb_rd_mem_resp #(
  parameter int ADDR_W = 16,
  parameter int LEN_W  = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic [LEN_W-1:0]  len,
  input  logic              avalid,
  output logic              aready,
  output logic [DATA_W-1:0] data,
  output logic              last,
  output logic              valid,
  input  logic              ready,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic {IDLE, BURST} state_t;

  localparam logic [LEN_W:0] ONE_BEAT = (LEN_W + 1)'(1);

  state_t            state, state_next;
  logic [ADDR_W-1:0] cur_addr;
  logic [LEN_W:0]    beats_left;   // one bit wider so 2^LEN_W beats fit
  logic              mem_last;     // is_last tag travelling with mem_rd
  logic              rd_pending;   // RAM word on mem_rdata this cycle
  logic              pend_last;    // is_last tag travelling with rd_pending

  logic [DATA_W-1:0] fifo_data [3];
  logic              fifo_last [3];
  logic [1:0]        wr_ptr, rd_ptr, fifo_count;

  logic              a_hs, pop, push;
  logic              issue, issue_last;
  logic [ADDR_W-1:0] issue_addr;
  logic [2:0]        inflight;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  assign a_hs  = avalid && aready;
  assign valid = (fifo_count != 2'd0);
  assign pop   = valid && ready;
  assign push  = rd_pending;
  assign data  = valid ? fifo_data[rd_ptr] : '0;
  assign last  = valid && fifo_last[rd_ptr];

  // Words already committed to the FIFO: stored, arriving now, or requested now.
  assign inflight = 3'(fifo_count) + 3'(rd_pending) + 3'(mem_rd);

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is updated with non-blocking assignments only, so every
    // register samples the values from before the edge regardless of block order.
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state and read-issue decision.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned
    // (an unassigned path would infer a latch).
    state_next = state;
    issue      = 1'b0;
    issue_last = 1'b0;
    issue_addr = cur_addr;
    unique case (state)
      IDLE: begin
        // The first read goes out on the handshake edge itself; the FIFO is empty
        // here, so credit is always available.
        if (a_hs) begin
          state_next = BURST;
          issue      = 1'b1;
          issue_addr = addr;
          issue_last = (len == '0);
        end
      end
      BURST: begin
        // A beat leaving the FIFO this edge frees its slot for a new read.
        if (beats_left != '0 && (inflight - 3'(pop)) < 3'd3) begin
          issue      = 1'b1;
          issue_last = (beats_left == ONE_BEAT);
        end
        if (pop && last) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Address counter, RAM request pipeline, handshake flag and FIFO bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      aready     <= 1'b0;
      mem_rd     <= 1'b0;
      mem_addr   <= '0;
      mem_last   <= 1'b0;
      rd_pending <= 1'b0;
      pend_last  <= 1'b0;
      cur_addr   <= '0;
      beats_left <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      aready     <= (state_next == IDLE);
      mem_rd     <= issue;
      mem_last   <= issue_last;
      if (issue) mem_addr <= issue_addr;
      rd_pending <= mem_rd;
      pend_last  <= mem_last;

      // beats_left counts reads still to issue; the handshake already issued one.
      if (a_hs) begin
        cur_addr   <= addr + ADDR_W'(1);
        beats_left <= {1'b0, len};
      end else if (issue) begin
        cur_addr   <= cur_addr + ADDR_W'(1);
        beats_left <= beats_left - ONE_BEAT;
      end

      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      fifo_count <= fifo_count + 2'(push) - 2'(pop);
    end
  end

  // FIFO storage: returned RAM word and its tag written the cycle they arrive.
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; fifo_count gates every read of it,
    // and data/last are forced to zero while the FIFO is empty.
    if (push) begin
      fifo_data[wr_ptr] <= mem_rdata;
      fifo_last[wr_ptr] <= pend_last;
    end
  end

endmodule

// File: tb/tb_anb_rd_mem_resp.sv
// Self-checking bench for anb_rd_mem_resp: RAM model with RAM[i] = i*0x11, a
// scoreboard fed at each address handshake, and one task per scenario.
module tb_anb_rd_mem_resp;

  localparam int ADDR_W = 16;
  localparam int LEN_W  = 8;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              last;
  } beat_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [ADDR_W-1:0] addr = '0;
  logic [LEN_W-1:0]  len = '0;
  logic              avalid = 1'b0;
  logic              aready;
  logic [DATA_W-1:0] data;
  logic              last;
  logic              valid;
  logic              ready = 1'b1;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  beat_t             exp_q[$];
  logic [ADDR_W-1:0] exp_addr_q[$];
  int                n_issued = 0;
  int                n_popped = 0;
  logic              stall_prev = 1'b0;
  logic [DATA_W-1:0] prev_data = '0;
  logic              prev_last = 1'b0;

  anb_rd_mem_resp #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .len(len), .avalid(avalid), .aready(aready),
    .data(data), .last(last), .valid(valid), .ready(ready),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata)
  );

  function automatic logic [DATA_W-1:0] ram_word(input logic [ADDR_W-1:0] a);
    return DATA_W'(a) * 32'h11;
  endfunction

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (mem_rd) mem_rdata <= ram_word(mem_addr);

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard: expectations pushed at each address handshake, checked on every
  // RAM read and every data beat; also checks stability under backpressure and
  // that no more than 3 words are ever outstanding.
  task automatic monitor();
    logic [ADDR_W-1:0] a;
    beat_t b;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        exp_addr_q.delete();
        n_issued   = 0;
        n_popped   = 0;
        stall_prev = 1'b0;
      end else begin
        if (avalid && aready) begin
          for (int i = 0; i <= int'(len); i++) begin
            a = addr + ADDR_W'(i);
            exp_addr_q.push_back(a);
            exp_q.push_back(beat_t'{data: ram_word(a), last: (i == int'(len))});
          end
        end
        if (mem_rd) begin
          n_issued++;
          checks++;
          if (exp_addr_q.size() == 0) begin
            errors++;
            $display("FAIL mem_addr: unexpected read at 0x%h, required no read", mem_addr);
          end else begin
            a = exp_addr_q.pop_front();
            if (mem_addr !== a) begin
              errors++;
              $display("FAIL mem_addr: got 0x%h expected 0x%h", mem_addr, a);
            end
          end
          checks++;
          if (n_issued - n_popped > 3) begin
            errors++;
            $display("FAIL credit: outstanding %0d, required at most 3", n_issued - n_popped);
          end
        end
        if (stall_prev) begin
          checks++;
          if (valid !== 1'b1 || data !== prev_data || last !== prev_last) begin
            errors++;
            $display("FAIL stable: got valid=%b data=0x%h last=%b, required valid=1 data=0x%h last=%b",
                     valid, data, last, prev_data, prev_last);
          end
        end
        if (valid && ready) begin
          n_popped++;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL beat: unexpected beat data=0x%h last=%b, required none", data, last);
          end else begin
            b = exp_q.pop_front();
            if (data !== b.data || last !== b.last) begin
              errors++;
              $display("FAIL beat: got data=0x%h last=%b expected data=0x%h last=%b",
                       data, last, b.data, b.last);
            end
          end
        end
        stall_prev = valid && !ready;
        prev_data  = data;
        prev_last  = last;
      end
    end
  endtask

  // Drive a request and wait (bounded) for its handshake; t = handshake cycle.
  task automatic start_req(input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] l, output int t);
    t = -1;
    addr = a; len = l; avalid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (aready) begin t = cyc; break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    avalid = 1'b0;
    checks++;
    if (t < 0) begin
      errors++;
      $display("FAIL handshake_timeout: aready never seen for addr 0x%h", a);
    end
  endtask

  // Run the data phase with a ready pattern until aready returns.
  // mode 0: ready=1; 1: 1,0,0 repeating; 2: 10-clk stall; 3: random.
  task automatic wait_done(input int mode, input int n_beats, output int first_rd,
                           output int first_v, output int last_c, output int ardy_c);
    int issued, popped;
    issued = 0; popped = 0;
    first_rd = -1; first_v = -1; last_c = -1; ardy_c = -1;
    for (int k = 0; k < 4000; k++) begin
      case (mode)
        1:       ready = (k % 3 == 0);
        2:       ready = !(k >= 3 && k < 13);
        3:       ready = ($urandom_range(0, 3) != 0);
        default: ready = 1'b1;
      endcase
      @(negedge clk);
      if (mem_rd) begin
        issued++;
        if (first_rd < 0) first_rd = cyc;
      end
      if (first_v < 0 && valid) first_v = cyc;
      if (mode == 2 && k == 12) begin
        checks++;
        if (mem_rd !== 1'b0 || valid !== 1'b1 || issued - popped != 3) begin
          errors++;
          $display("FAIL stall_credit: mem_rd=%b valid=%b outstanding=%0d, required mem_rd=0 valid=1 outstanding=3",
                   mem_rd, valid, issued - popped);
        end
      end
      if (last_c >= 0 && aready) begin ardy_c = cyc; break; end
      if (valid && ready) begin
        popped++;
        if (last) last_c = cyc;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    ready = 1'b1;
    checks++;
    if (ardy_c < 0) begin
      errors++;
      $display("FAIL burst_timeout: burst of %0d beats did not complete", n_beats);
    end
    checks++;
    if (issued != n_beats || popped != n_beats) begin
      errors++;
      $display("FAIL beat_count: reads=%0d beats=%0d, required %0d each", issued, popped, n_beats);
    end
    checks++;
    if (exp_q.size() != 0 || exp_addr_q.size() != 0) begin
      errors++;
      $display("FAIL leftover: %0d beats and %0d reads never seen, required 0",
               exp_q.size(), exp_addr_q.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; avalid = 1'b1; addr = 16'h0010; len = 8'd3; ready = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    @(negedge clk);
    checks++;
    if (aready !== 1'b0 || valid !== 1'b0 || mem_rd !== 1'b0 || last !== 1'b0 ||
        data !== '0 || mem_addr !== '0) begin
      errors++;
      $display("FAIL reset_values: aready=%b valid=%b mem_rd=%b last=%b data=0x%h mem_addr=0x%h, required all 0",
               aready, valid, mem_rd, last, data, mem_addr);
    end
    @(posedge clk); #1;
    rst_n = 1'b1; avalid = 1'b0;
    @(negedge clk);
    checks++;
    if (aready !== 1'b0) begin
      errors++;
      $display("FAIL aready_release: got %b in release cycle, required 0", aready);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (aready !== 1'b1) begin
      errors++;
      $display("FAIL aready_after: got %b one clk after release, required 1", aready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int t, f_rd, f_v, l_c, a_c;
    ready = 1'b1;
    start_req(16'h0010, 8'd3, t);
    wait_done(0, 4, f_rd, f_v, l_c, a_c);
    checks++;
    if (f_rd != t + 1 || f_v != t + 3 || l_c != t + 6 || a_c != t + 7) begin
      errors++;
      $display("FAIL latency: mem_rd@%0d valid@%0d last@%0d aready@%0d, required %0d %0d %0d %0d",
               f_rd - t, f_v - t, l_c - t, a_c - t, 1, 3, 6, 7);
    end
  endtask

  task automatic test_backpressure();
    int t, f_rd, f_v, l_c, a_c;
    start_req(16'h0010, 8'd3, t);
    wait_done(1, 4, f_rd, f_v, l_c, a_c);
    start_req(16'h0010, 8'd7, t);
    wait_done(2, 8, f_rd, f_v, l_c, a_c);
  endtask

  task automatic test_boundaries();
    int t, f_rd, f_v, l_c, a_c;
    start_req(16'hFFFE, 8'd3, t);
    wait_done(0, 4, f_rd, f_v, l_c, a_c);
    start_req(16'h0020, 8'd0, t);
    wait_done(0, 1, f_rd, f_v, l_c, a_c);
    checks++;
    if (f_v != t + 3 || l_c != t + 3 || a_c != t + 4) begin
      errors++;
      $display("FAIL single_beat: valid@%0d last@%0d aready@%0d, required 3 3 4",
               f_v - t, l_c - t, a_c - t);
    end
    start_req(16'h1234, 8'hFF, t);
    wait_done(3, 256, f_rd, f_v, l_c, a_c);
  endtask

  task automatic test_back_to_back();
    int ta, tb2, last_a, f_rd, f_v, l_c, a_c;
    ready = 1'b1;
    start_req(16'h0100, 8'd2, ta);
    avalid = 1'b1; addr = 16'h0200; len = 8'd1;
    last_a = -1; tb2 = -1;
    for (int i = 0; i < 50 && tb2 < 0; i++) begin
      @(negedge clk);
      if (aready) tb2 = cyc;
      else if (valid && ready && last && last_a < 0) last_a = cyc;
      if (tb2 < 0) begin @(posedge clk); #1; end
    end
    @(posedge clk); #1;
    avalid = 1'b0;
    checks++;
    if (last_a != ta + 5 || tb2 != last_a + 1) begin
      errors++;
      $display("FAIL second_accept: first last@%0d second handshake@%0d, required last@%0d handshake@%0d",
               last_a - ta, tb2 - ta, 5, 6);
    end
    wait_done(0, 2, f_rd, f_v, l_c, a_c);
    checks++;
    if (f_v != tb2 + 3 || l_c != tb2 + 4) begin
      errors++;
      $display("FAIL second_timing: valid@%0d last@%0d, required 3 4", f_v - tb2, l_c - tb2);
    end
  endtask

  task automatic test_reset_mid_burst();
    int t, pops, f_rd, f_v, l_c, a_c;
    ready = 1'b1;
    pops = 0;
    start_req(16'h0300, 8'd7, t);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (valid && ready) pops++;
      if (pops == 2) break;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (aready !== 1'b0 || valid !== 1'b0 || mem_rd !== 1'b0 || last !== 1'b0 ||
        data !== '0 || mem_addr !== '0 || pops != 2) begin
      errors++;
      $display("FAIL mid_reset: aready=%b valid=%b mem_rd=%b last=%b data=0x%h mem_addr=0x%h beats=%0d, required zeros and 2 beats",
               aready, valid, mem_rd, last, data, mem_addr, pops);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    start_req(16'h0400, 8'd4, t);
    wait_done(0, 5, f_rd, f_v, l_c, a_c);
    checks++;
    if (f_v != t + 3) begin
      errors++;
      $display("FAIL fresh_burst: first valid@%0d, required 3", f_v - t);
    end
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_basic();
    test_backpressure();
    test_boundaries();
    test_back_to_back();
    test_reset_mid_burst();
    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
